// File: rtl/gsm_pkg.sv
// rtl/gsm_pkg.sv - shared helpers for the grouped-shared-memory multicast core
package gsm_pkg;

    function automatic int refcnt_width(input int log_nport);
        return log_nport + 1;
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    // One-hot grant of the first requester after 'last', searching n ports cyclically
    function automatic logic [31:0] rr_next(input logic [31:0] req, input int last, input int n);
        logic [31:0] g;
        logic        found;
        int          idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= n; i++) begin
            idx = (last + i) % n;
            if (!found && req[idx[4:0]]) begin
                g[idx[4:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/gsm_mcast_ram_if.sv
// rtl/gsm_mcast_ram_if.sv - write, egress and buffer-free signals of gsm_mcast_ram
interface gsm_mcast_ram_if #(
    parameter int NPORT  = 4,
    parameter int DWIDTH = 128,
    parameter int AWIDTH = 9
);
    logic              i_wr_en;
    logic [AWIDTH-1:0] i_wr_addr;
    logic [DWIDTH-1:0] i_wr_data;
    logic [NPORT-1:0]  i_multicast;
    logic              o_wr_ready;
    logic [NPORT-1:0]  i_egress_stall;
    logic [NPORT-1:0]  o_egress_sel;
    logic [DWIDTH-1:0] o_egress_data;
    logic              o_buf_free;
    logic [AWIDTH-1:0] o_buf_free_addr;
    logic              o_drop;
    logic              o_err_overwrite;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_multicast, i_egress_stall,
        input  o_wr_ready, o_egress_sel, o_egress_data, o_buf_free, o_buf_free_addr,
               o_drop, o_err_overwrite
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_multicast, i_egress_stall,
        output o_wr_ready, o_egress_sel, o_egress_data, o_buf_free, o_buf_free_addr,
               o_drop, o_err_overwrite
    );
endinterface

// File: rtl/gsm_addr_queue.sv
// rtl/gsm_addr_queue.sv - per-port cell-address FIFO with exact full/empty
module gsm_addr_queue #(
    parameter int AWIDTH = 9,
    parameter int QLOG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [AWIDTH-1:0] din,
    input  logic              pop,
    output logic [AWIDTH-1:0] dout,
    output logic              full,
    output logic              empty
);
    logic [AWIDTH-1:0] mem [2**QLOG];
    logic [QLOG:0]     wr_ptr;
    logic [QLOG:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit separates full from empty when the index bits match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[QLOG] != rd_ptr[QLOG]) && (wr_ptr[QLOG-1:0] == rd_ptr[QLOG-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[QLOG-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[QLOG-1:0]] <= din;
    end
endmodule

// File: rtl/gsm_mcast_ram.sv
// rtl/gsm_mcast_ram.sv - central cell RAM with per-port address queues and multicast refcounts
module gsm_mcast_ram
    import gsm_pkg::*;
#(
    parameter int NPORT     = 4,
    parameter int LOG_NPORT = 2,
    parameter int DWIDTH    = 128,
    parameter int AWIDTH    = 9,
    parameter int QLOG      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    gsm_mcast_ram_if.slave bus
);
    localparam int RCW = refcnt_width(LOG_NPORT);

    logic [DWIDTH-1:0]    ram [2**AWIDTH];
    logic [DWIDTH-1:0]    ram_q;
    logic [RCW-1:0]       refcnt [2**AWIDTH];

    logic [AWIDTH-1:0]    q_dout [NPORT];
    logic [NPORT-1:0]     q_full;
    logic [NPORT-1:0]     q_empty;
    logic [NPORT-1:0]     q_push;
    logic [NPORT-1:0]     eligible;
    logic [NPORT-1:0]     gnt;
    logic [LOG_NPORT-1:0] gnt_idx;
    logic [AWIDTH-1:0]    gnt_addr;
    logic [RCW-1:0]       gnt_ref;
    logic [RCW-1:0]       cur_ref;
    logic [LOG_NPORT-1:0] last_grant;

    logic                 wr_ready;
    logic                 reject_drop;
    logic                 reject_ovw;
    logic                 accept;

    logic [NPORT-1:0]     sel_r;
    logic                 free_r;
    logic [AWIDTH-1:0]    free_addr_r;
    logic                 drop_r;
    logic                 err_r;

    assign wr_ready    = &(~q_full);
    assign cur_ref     = refcnt[bus.i_wr_addr];
    assign reject_drop = bus.i_wr_en & (~wr_ready | (bus.i_multicast == '0));
    assign reject_ovw  = bus.i_wr_en & ~reject_drop & (cur_ref != '0);
    assign accept      = bus.i_wr_en & ~reject_drop & (cur_ref == '0);
    assign q_push      = accept ? bus.i_multicast : '0;

    assign eligible    = ~q_empty & ~bus.i_egress_stall;
    assign gnt         = NPORT'(rr_next(32'(eligible), int'(last_grant), NPORT));

    always_comb begin
        gnt_idx  = '0;
        gnt_addr = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (gnt[p]) begin
                gnt_idx  = LOG_NPORT'(p);
                gnt_addr = q_dout[p];
            end
        end
    end

    assign gnt_ref = refcnt[gnt_addr];

    for (genvar p = 0; p < NPORT; p++) begin : g_q
        gsm_addr_queue #(.AWIDTH(AWIDTH), .QLOG(QLOG)) u_q (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .push  (q_push[p]),
            .din   (bus.i_wr_addr),
            .pop   (gnt[p]),
            .dout  (q_dout[p]),
            .full  (q_full[p]),
            .empty (q_empty[p])
        );
    end

    // An accepted write always targets a zero refcount while the granted cell is
    // nonzero, so the two updates never collide on one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 2**AWIDTH; a++) refcnt[a] <= '0;
        end else if (clr) begin
            for (int a = 0; a < 2**AWIDTH; a++) refcnt[a] <= '0;
        end else begin
            if (accept) refcnt[bus.i_wr_addr] <= RCW'(popcount(32'(bus.i_multicast)));
            if (|gnt)   refcnt[gnt_addr]      <= gnt_ref - RCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r       <= '0;
            free_r      <= 1'b0;
            free_addr_r <= '0;
            drop_r      <= 1'b0;
            err_r       <= 1'b0;
            last_grant  <= LOG_NPORT'(NPORT - 1);
        end else if (clr) begin
            sel_r       <= '0;
            free_r      <= 1'b0;
            free_addr_r <= '0;
            drop_r      <= 1'b0;
            err_r       <= 1'b0;
            last_grant  <= LOG_NPORT'(NPORT - 1);
        end else begin
            sel_r       <= gnt;
            free_r      <= (|gnt) & (gnt_ref == RCW'(1));
            free_addr_r <= ((|gnt) & (gnt_ref == RCW'(1))) ? gnt_addr : '0;
            drop_r      <= reject_drop;
            err_r       <= reject_ovw;
            if (|gnt) last_grant <= gnt_idx;
        end
    end

    // Cell storage stays unreset so it maps onto a block RAM with a registered read
    always_ff @(posedge clk) begin
        if (accept) ram[bus.i_wr_addr] <= bus.i_wr_data;
        ram_q <= ram[gnt_addr];
    end

    assign bus.o_wr_ready      = wr_ready;
    assign bus.o_egress_sel    = sel_r;
    assign bus.o_egress_data   = (|sel_r) ? ram_q : '0;
    assign bus.o_buf_free      = free_r;
    assign bus.o_buf_free_addr = free_addr_r;
    assign bus.o_drop          = drop_r;
    assign bus.o_err_overwrite = err_r;
endmodule

// File: tb/tb_gsm_mcast_ram.sv
// tb/tb_gsm_mcast_ram.sv - directed scoreboard bench for gsm_mcast_ram
module tb_gsm_mcast_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    gsm_mcast_ram_if #(.NPORT(4), .DWIDTH(128), .AWIDTH(9)) bus ();

    gsm_mcast_ram #(.NPORT(4), .LOG_NPORT(2), .DWIDTH(128), .AWIDTH(9), .QLOG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   sel;
        logic [127:0] data;
        logic         free;
        logic [8:0]   faddr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [8:0] a, input logic [3:0] m, input logic [127:0] d);
        bus.i_wr_en     = 1'b1;
        bus.i_wr_addr   = a;
        bus.i_multicast = m;
        bus.i_wr_data   = d;
        tick();
        bus.i_wr_en     = 1'b0;
    endtask

    task automatic expect_out(input logic [3:0] s, input logic [127:0] d, input logic f, input logic [8:0] fa);
        exp_t e;
        e.sel = s; e.data = d; e.free = f; e.faddr = fa;
        sb.push_back(e);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},  128'(bus.o_egress_sel), 128'd0);
        chk({tag, "_data"}, bus.o_egress_data, 128'd0);
        chk({tag, "_free"}, 128'(bus.o_buf_free), 128'd0);
        chk({tag, "_faddr"}, 128'(bus.o_buf_free_addr), 128'd0);
        chk({tag, "_drop"}, 128'(bus.o_drop), 128'd0);
        chk({tag, "_err"},  128'(bus.o_err_overwrite), 128'd0);
    endtask

    // Every egress/free output observed in operation must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n && (bus.o_egress_sel != 4'd0 || bus.o_buf_free)) begin
            if (sb.size() == 0) begin
                chk("unexpected_egress", 128'({bus.o_egress_sel, bus.o_buf_free}), 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("egress_sel",  128'(bus.o_egress_sel), 128'(e.sel));
                chk("egress_data", bus.o_egress_data, e.data);
                chk("buf_free",    128'(bus.o_buf_free), 128'(e.free));
                chk("buf_free_addr", 128'(bus.o_buf_free_addr), 128'(e.faddr));
            end
        end
    end

    initial begin
        logic [127:0] d;
        bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_multicast = '0; bus.i_egress_stall = '0;

        // reset state
        #1;
        chk_all_zero("reset");
        idle(2);
        rst_n = 1'b1;
        tick();
        chk("reset_wr_ready", 128'(bus.o_wr_ready), 128'd1);

        // unicast with latency check
        d = {16{8'hA5}};
        expect_out(4'b0001, d, 1'b1, 9'd5);
        wr(9'd5, 4'b0001, d);
        chk("uni_drop", 128'(bus.o_drop), 128'd0);
        chk("uni_sel_early", 128'(bus.o_egress_sel), 128'd0);
        tick();
        chk("uni_sel", 128'(bus.o_egress_sel), 128'h1);
        chk("uni_free", 128'(bus.o_buf_free), 128'd1);
        idle(3);

        // broadcast from a cleared arbiter: ports 0..3, free with port 3
        do_clr();
        chk_all_zero("clr");
        d = {16{8'hD7}};
        expect_out(4'b0001, d, 1'b0, 9'd0);
        expect_out(4'b0010, d, 1'b0, 9'd0);
        expect_out(4'b0100, d, 1'b0, 9'd0);
        expect_out(4'b1000, d, 1'b1, 9'd7);
        wr(9'd7, 4'b1111, d);
        idle(6);

        // stall port 0: port 1 served, port 0 waits
        bus.i_egress_stall = 4'b0001;
        d = {16{8'h99}};
        expect_out(4'b0010, d, 1'b0, 9'd0);
        expect_out(4'b0001, d, 1'b1, 9'd9);
        wr(9'd9, 4'b0011, d);
        idle(5);
        chk("stall_pending", 128'(sb.size()), 128'd1);
        bus.i_egress_stall = 4'b0000;
        idle(3);

        // overwrite of a live cell
        bus.i_egress_stall = 4'b0100;
        d = {16{8'h31}};
        expect_out(4'b0100, d, 1'b1, 9'd3);
        wr(9'd3, 4'b0100, d);
        chk("ovw_first_err", 128'(bus.o_err_overwrite), 128'd0);
        wr(9'd3, 4'b0100, {16{8'h32}});
        chk("ovw_err", 128'(bus.o_err_overwrite), 128'd1);
        chk("ovw_drop", 128'(bus.o_drop), 128'd0);
        tick();
        chk("ovw_err_pulse", 128'(bus.o_err_overwrite), 128'd0);
        bus.i_egress_stall = 4'b0000;
        idle(3);

        // zero mask is dropped
        wr(9'd11, 4'b0000, {16{8'h11}});
        chk("zero_mask_drop", 128'(bus.o_drop), 128'd1);
        idle(2);

        // fill queue 0, overflow drop, drain in order across the pointer wrap
        bus.i_egress_stall = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            d = {112'h0, 16'(16'hC000 + i)};
            expect_out(4'b0001, d, 1'b1, 9'(20 + i));
            wr(9'(20 + i), 4'b0001, d);
            chk("fill_drop", 128'(bus.o_drop), 128'd0);
            if (i == 14) chk("ready_at_15", 128'(bus.o_wr_ready), 128'd1);
        end
        chk("ready_full", 128'(bus.o_wr_ready), 128'd0);
        wr(9'd40, 4'b0001, {16{8'hEE}});
        chk("full_drop", 128'(bus.o_drop), 128'd1);
        bus.i_egress_stall = 4'b0000;
        idle(20);
        chk("drain_done", 128'(sb.size()), 128'd0);
        chk("ready_after_drain", 128'(bus.o_wr_ready), 128'd1);

        // asynchronous reset in the middle of a broadcast
        do_clr();
        d = {16{8'h50}};
        expect_out(4'b0001, d, 1'b0, 9'd0);
        wr(9'd50, 4'b1111, d);
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(10);
        d = {16{8'h51}};
        expect_out(4'b0001, d, 1'b1, 9'd50);
        wr(9'd50, 4'b0001, d);
        chk("post_reset_err", 128'(bus.o_err_overwrite), 128'd0);
        chk("post_reset_drop", 128'(bus.o_drop), 128'd0);
        idle(4);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
